imem_loader: RTL and testbench

- Writer side of the dual-lane instruction memory: takes a byte stream over a valid/ready handshake and assembles 32-bit little-endian instruction words.
- Writes those words into the instruction block RAM that the processor fetches from. Lane A occupies words 0..511 and lane B starts at word 512.
- Asserts a hold to the processor while a load is in progress, so the PC does not advance against a half-written program.

---
 rtl/imem_loader.sv | 178 +++++++++++++++++
 tb/tb_imem_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to the lane A/B instruction RAM; optional checksum via IMEM_LOADER_CHECKSUM_EN.
// Latency: mem_we fires the cycle after the 4th byte of a word; done/err/hold update one cycle after the deciding byte.
// Backpressure: in_ready is low only in the single WRITE cycle; in_valid gaps simply stall the FSM with state held.
module imem_loader #(
    parameter int         LANE_DEPTH = 512,
    parameter int         ADDR_W     = 32,
    parameter logic [7:0] CMD_A      = 8'hA5,
    parameter logic [7:0] CMD_B      = 8'hB5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              hold,
    output logic              done,
    output logic              err,
    output logic [9:0]        words_written
);
    typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, WRITE, CSUM} state_t;

    localparam logic [15:0] DEPTH16 = 16'(LANE_DEPTH);

    state_t      state_q, state_d;
    logic        lane_q, lane_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;
    logic [9:0]  words_q, words_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic        acc;
    logic [15:0] cnt_full;

    assign acc      = in_valid & in_ready;
    assign cnt_full = {in_data, cnt_q[7:0]};

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        words_d = words_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (acc && (in_data == CMD_A || in_data == CMD_B)) begin
                    lane_d  = (in_data == CMD_B);
                    err_d   = 1'b0;
                    words_d = '0;
                    hold_d  = 1'b1;
                    idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = CNT_LO;
                end
            end
            CNT_LO: begin
                if (acc) begin
                    cnt_d[7:0] = in_data;
                    state_d    = CNT_HI;
                end
            end
            CNT_HI: begin
                if (acc) begin
                    cnt_d = cnt_full;
                    if (cnt_full > DEPTH16) begin
                        err_d   = 1'b1;
                        hold_d  = 1'b0;
                        state_d = IDLE;
                    end else if (cnt_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CSUM;
`else
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        state_d = IDLE;
`endif
                    end else begin
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (acc) begin
                    // Shift in from the top so the first byte ends up in [7:0]
                    asm_d = {in_data, asm_q[31:8]};
                    idx_d = idx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_data;
`endif
                    if (idx_q == 2'd3) state_d = WRITE;
                end
            end
            WRITE: begin
                words_d = words_q + 10'd1;
                if (({6'd0, words_q} + 16'd1) < cnt_q) begin
                    state_d = DATA;
                end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                    state_d = IDLE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (acc) begin
                    if (in_data == csum_q) done_d = 1'b1;
                    else                   err_d  = 1'b1;
                    hold_d  = 1'b0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lane_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            words_q <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            words_q <= words_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign in_ready      = (state_q != WRITE);
    assign mem_we        = (state_q == WRITE);
    assign mem_addr      = (lane_q ? ADDR_W'(LANE_DEPTH) : '0) + ADDR_W'(words_q);
    assign mem_wdata     = asm_q;
    assign hold          = hold_q;
    assign done          = done_q;
    assign err           = err_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected RAM writes and done pulses are queued by the stimulus and consumed by a monitor.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        hold;
    logic        done;
    logic        err;
    logic [9:0]  words_written;

    imem_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .hold(hold),
        .done(done), .err(err), .words_written(words_written)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        wq[$];
    int         dones_expected = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] frame[$];
    logic       prev_we = 1'b0;
    logic       prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write and done pulse must match something the stimulus queued.
    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready_vs_write", in_ready, !mem_we);
            if (mem_we) begin
                if (wq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write", mem_addr, mem_wdata);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("write_addr", mem_addr, e.addr);
                    chk("write_data", mem_wdata, e.data);
                end
                if (prev_we) begin
                    n_checks++; n_fail++;
                    $display("FAIL we_width: mem_we high 2 cycles, expected 1");
                end
            end
            if (done) begin
                if (dones_expected == 0 || prev_done) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_done: done=1, expected 0");
                end else begin
                    n_checks++;
                    dones_expected--;
                end
            end
            prev_we   = mem_we;
            prev_done = done;
        end else begin
            prev_we   = 1'b0;
            prev_done = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL handshake_timeout: in_ready=0 for 50 cycles, expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap);
        for (int i = 0; i < frame.size(); i++) begin
            send_byte(frame[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            if (i < frame.size() - 1) chk("hold_in_frame", hold, 1'b1);
        end
        frame.delete();
    endtask

    task automatic push_word(input logic [31:0] addr, input logic [31:0] w);
        wq.push_back({addr, w});
        for (int k = 0; k < 4; k++) frame.push_back(w[8*k +: 8]);
    endtask

    task automatic settle();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  cs;
        logic [31:0] w;
        // Reset state
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_hold", hold, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_words", words_written, 10'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Lane A, two words
        frame = '{8'hA5, 8'h02, 8'h00};
        push_word(32'd0, 32'h00000013);
        push_word(32'd1, 32'h00100093);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(8'h90);
`endif
        dones_expected++;
        send_frame(0);
        settle();
        chk("laneA_hold", hold, 1'b0);
        chk("laneA_err", err, 1'b0);
        chk("laneA_words", words_written, 10'd2);
        chk("laneA_done_seen", dones_expected, 0);

        // Lane B base
        frame = '{8'hB5, 8'h01, 8'h00};
        push_word(32'd512, 32'hDEADBEEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(8'h22);
`endif
        dones_expected++;
        send_frame(0);
        settle();
        chk("laneB_words", words_written, 10'd1);
        chk("laneB_done_seen", dones_expected, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum: writes happen, no done
        frame = '{8'hA5, 8'h02, 8'h00};
        push_word(32'd0, 32'h00000013);
        push_word(32'd1, 32'h00100093);
        frame.push_back(8'h81);
        send_frame(0);
        settle();
        chk("badcs_err", err, 1'b1);
        chk("badcs_hold", hold, 1'b0);
        chk("badcs_words", words_written, 10'd2);
`endif

        // Oversize count, then a stray byte in IDLE
        frame = '{8'hA5, 8'h01, 8'h02};
        send_frame(0);
        settle();
        chk("over_err", err, 1'b1);
        chk("over_hold", hold, 1'b0);
        chk("over_words", words_written, 10'd0);
        send_byte(8'h13, 0);
        settle();
        chk("idle_ignore_err", err, 1'b1);
        chk("idle_ignore_hold", hold, 1'b0);

        // Zero-length load clears err
        frame = '{8'hA5, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(8'h00);
`endif
        dones_expected++;
        send_frame(0);
        settle();
        chk("zero_err_cleared", err, 1'b0);
        chk("zero_hold", hold, 1'b0);
        chk("zero_done_seen", dones_expected, 0);

        // Backpressure: random in_valid gaps, lane A, three words
        frame = '{8'hA5, 8'h03, 8'h00};
        push_word(32'd0, 32'h11223344);
        push_word(32'd1, 32'h55667788);
        push_word(32'd2, 32'h99AABBCC);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(8'hCC);
`endif
        dones_expected++;
        send_frame(3);
        settle();
        chk("bp_words", words_written, 10'd3);
        chk("bp_done_seen", dones_expected, 0);

        // Full lane B: 512 words, last address 1023
        frame = '{8'hB5, 8'h00, 8'h02};
        cs = '0;
        for (int i = 0; i < 512; i++) begin
            w = 32'h5A000000 | 32'(i);
            push_word(32'd512 + 32'(i), w);
            cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(cs);
`endif
        dones_expected++;
        send_frame(0);
        settle();
        chk("full_words", words_written, 10'd512);
        chk("full_err", err, 1'b0);
        chk("full_done_seen", dones_expected, 0);

        // Async reset after the second data byte of a lane B frame
        frame = '{8'hB5, 8'h01, 8'h00, 8'h77, 8'h66};
        send_frame(0);
        #1 rst = 1'b0;
        #1;
        chk("arst_hold", hold, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_wdata", mem_wdata, 32'd0);
        chk("arst_we", mem_we, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        frame = '{8'hA5, 8'h01, 8'h00};
        push_word(32'd0, 32'hCAFEF00D);
`ifdef IMEM_LOADER_CHECKSUM_EN
        frame.push_back(8'hC9);
`endif
        dones_expected++;
        send_frame(1);
        settle();
        chk("post_rst_words", words_written, 10'd1);
        chk("post_rst_done_seen", dones_expected, 0);
        chk("writes_drained", wq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
